// File: rtl/uart_codes_pkg.sv
// Shared constants for the button-to-UART encoder and its matching decoder.
// Holds the press/release byte codes, the release mask, the button index
// constants (bit positions inside btn_state) and the encoder FSM encoding.
package uart_codes_pkg;

  localparam int NUM_BTN = 5;

  // Bit positions inside btn_state = {Attack, Up, Left, Right, Down}
  localparam logic [2:0] IDX_ATTACK = 3'd4;
  localparam logic [2:0] IDX_UP     = 3'd3;
  localparam logic [2:0] IDX_LEFT   = 3'd2;
  localparam logic [2:0] IDX_RIGHT  = 3'd1;
  localparam logic [2:0] IDX_DOWN   = 3'd0;

  localparam logic [7:0] RELEASE_MASK = 8'h20;

  localparam logic [7:0] CODE_ATTACK_PRESS = 8'h20;
  localparam logic [7:0] CODE_UP_PRESS     = 8'h57;
  localparam logic [7:0] CODE_LEFT_PRESS   = 8'h41;
  localparam logic [7:0] CODE_DOWN_PRESS   = 8'h53;
  localparam logic [7:0] CODE_RIGHT_PRESS  = 8'h44;

  // The mask toggles bit 5: letters go to lower case and Attack (0x20)
  // lands on 0x00, so one rule covers every button.
  localparam logic [7:0] CODE_ATTACK_RELEASE = CODE_ATTACK_PRESS ^ RELEASE_MASK;
  localparam logic [7:0] CODE_UP_RELEASE     = CODE_UP_PRESS     ^ RELEASE_MASK;
  localparam logic [7:0] CODE_LEFT_RELEASE   = CODE_LEFT_PRESS   ^ RELEASE_MASK;
  localparam logic [7:0] CODE_DOWN_RELEASE   = CODE_DOWN_PRESS   ^ RELEASE_MASK;
  localparam logic [7:0] CODE_RIGHT_RELEASE  = CODE_RIGHT_PRESS  ^ RELEASE_MASK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } enc_state_t;

  // Byte for a button at a given debounced level (1 = pressed).
  function automatic logic [7:0] btn_code(input logic [2:0] idx, input logic lvl);
    logic [7:0] code;
    case (idx)
      IDX_ATTACK: code = lvl ? CODE_ATTACK_PRESS : CODE_ATTACK_RELEASE;
      IDX_UP:     code = lvl ? CODE_UP_PRESS     : CODE_UP_RELEASE;
      IDX_LEFT:   code = lvl ? CODE_LEFT_PRESS   : CODE_LEFT_RELEASE;
      IDX_RIGHT:  code = lvl ? CODE_RIGHT_PRESS  : CODE_RIGHT_RELEASE;
      IDX_DOWN:   code = lvl ? CODE_DOWN_PRESS   : CODE_DOWN_RELEASE;
      default:    code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/uart_encode_if.sv
// Byte-write link between the button encoder and a UART transmitter FIFO.
//   uart_data : byte to transmit (encoder -> FIFO)
//   wr_uart   : single-cycle write strobe (encoder -> FIFO)
//   tx_full   : FIFO full flag, no write allowed while high (FIFO -> encoder)
interface uart_encode_if;
  logic [7:0] uart_data;
  logic       wr_uart;
  logic       tx_full;

  modport master (output uart_data, output wr_uart, input tx_full);
  modport slave  (input uart_data, input wr_uart, output tx_full);
endinterface

// File: rtl/button_debounce.sv
// One push button: 2-flop synchronizer followed by a counting debouncer.
//   clk, rst : system clock, synchronous active-high reset
//   btn_raw  : raw asynchronous button level, 1 = pressed
//   level    : debounced level (registered)
// The level follows the synchronized input only after the two have disagreed
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability synchronizer
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      // stage p1 -> level: debounce counter
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Nth consecutive differing cycle: accept. The counter stops at
        // CNT_LAST and is cleared here, so it can never wrap.
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_encode.sv
// Debounces five push buttons and reports each debounced press/release as
// one byte written into a UART transmitter FIFO.
//   clk, rst        : system clock, synchronous active-high reset
//   btnAttack..Down : raw asynchronous button levels, 1 = pressed
//   tx              : uart_encode_if master (uart_data, wr_uart out; tx_full in)
//   btn_state       : debounced levels {Attack, Up, Left, Right, Down}
// FSM IDLE -> SEND -> HOLD: a byte is chosen and latched in IDLE, strobed in
// SEND, and HOLD gives the FIFO one cycle to update tx_full before the next
// choice, so at most one byte leaves every three cycles.
module uart_encode
  import uart_codes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btnAttack,
  input  logic         btnUp,
  input  logic         btnLeft,
  input  logic         btnRight,
  input  logic         btnDown,
  uart_encode_if.master tx,
  output logic [4:0]   btn_state
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] sent_state;
  logic [NUM_BTN-1:0] pending;
  logic               sel_vld;
  logic [2:0]         sel_idx;
  enc_state_t         state;
  logic [7:0]         uart_data_q;
  logic               wr_uart_q;

  assign btn_raw = {btnAttack, btnUp, btnLeft, btnRight, btnDown};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[i]),
      .level  (level[i])
    );
  end

  assign btn_state = level;

  // A button owes a byte whenever its debounced level differs from what was
  // last reported; a press and release both landing before selection cancel.
  assign pending = level ^ sent_state;

  always_comb begin
    sel_vld = 1'b1;
    sel_idx = IDX_RIGHT;
    if      (pending[IDX_ATTACK]) sel_idx = IDX_ATTACK;
    else if (pending[IDX_UP])     sel_idx = IDX_UP;
    else if (pending[IDX_DOWN])   sel_idx = IDX_DOWN;
    else if (pending[IDX_LEFT])   sel_idx = IDX_LEFT;
    else if (pending[IDX_RIGHT])  sel_idx = IDX_RIGHT;
    else                          sel_vld = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      uart_data_q <= 8'h00;
      wr_uart_q   <= 1'b0;
      sent_state  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wr_uart_q <= 1'b0;
          if (sel_vld && !tx.tx_full) begin
            // The strobe is raised here so it is high exactly during SEND.
            uart_data_q         <= btn_code(sel_idx, level[sel_idx]);
            sent_state[sel_idx] <= level[sel_idx];
            wr_uart_q           <= 1'b1;
            state               <= SEND;
          end
        end
        SEND: begin
          // tx_full is ignored here: the write was granted when it was low.
          wr_uart_q <= 1'b0;
          state     <= HOLD;
        end
        HOLD: begin
          wr_uart_q <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          wr_uart_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign tx.uart_data = uart_data_q;
  assign tx.wr_uart   = wr_uart_q;

endmodule
